// File: rtl/data_memory_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : data_memory_arbiter                                           |
// | Brief    : two-port round-robin arbiter/sequencer for single-port DMEM   |
// | Config   : DMEM_ARB_FIXED_PRIO_EN selects fixed priority (port 0 first)  |
// | Revision : 1.0                                                           |
// +--------------------------------------------------------------------------+
module data_memory_arbiter #(
  parameter int ACCESS_CYCLES = 2,
  parameter int ADDR_W        = 64,
  parameter int DATA_W        = 64
) (
  input  logic              Clock,
  input  logic              Reset,
  input  logic              Req0,
  input  logic              Req1,
  input  logic              Wr0,
  input  logic              Wr1,
  input  logic [ADDR_W-1:0] Addr0,
  input  logic [ADDR_W-1:0] Addr1,
  input  logic [DATA_W-1:0] WData0,
  input  logic [DATA_W-1:0] WData1,
  output logic              Done0,
  output logic              Done1,
  output logic [DATA_W-1:0] RData0,
  output logic [DATA_W-1:0] RData1,
  output logic [ADDR_W-1:0] MemAddress,
  output logic [DATA_W-1:0] MemWriteData,
  output logic              MemRead,
  output logic              MemWrite,
  input  logic [DATA_W-1:0] MemReadData,
  output logic              Busy
);

  localparam int c_CNT_W = (ACCESS_CYCLES > 1) ? $clog2(ACCESS_CYCLES) : 1;
  localparam logic [c_CNT_W-1:0] c_CNT_LOAD = c_CNT_W'(ACCESS_CYCLES - 1);

  if (ACCESS_CYCLES < 1) begin : g_bad_access_cycles
    $error("data_memory_arbiter: ACCESS_CYCLES must be >= 1");
  end

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    ACCESS   = 2'd1,
    COMPLETE = 2'd2
  } state_t;

  state_t              r_state, w_state_nx;
  logic [c_CNT_W-1:0]  r_cnt, w_cnt_nx;
  logic                r_grant, w_grant_nx;
  logic                r_wr, w_wr_nx;
  logic [ADDR_W-1:0]   r_addr, w_addr_nx;
  logic [DATA_W-1:0]   r_wdata, w_wdata_nx;
  logic                r_rd_cmd, w_rd_cmd_nx;
  logic                r_wr_cmd, w_wr_cmd_nx;
  logic                r_done0, w_done0_nx;
  logic                r_done1, w_done1_nx;
  logic [DATA_W-1:0]   r_rdata0, w_rdata0_nx;
  logic [DATA_W-1:0]   r_rdata1, w_rdata1_nx;
  logic                r_busy, w_busy_nx;
  logic                w_tie_winner;
  logic                w_winner;
  logic                w_sel_wr;

`ifdef DMEM_ARB_FIXED_PRIO_EN
  assign w_tie_winner = 1'b0;
`else
  logic r_last_grant;

  // Tie goes to whichever port was not served most recently
  assign w_tie_winner = ~r_last_grant;

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      r_last_grant <= 1'b1;
    end else if ((r_state == IDLE) && (Req0 || Req1)) begin
      r_last_grant <= w_winner;
    end
  end
`endif

  assign w_winner = (Req0 && Req1) ? w_tie_winner : Req1;
  assign w_sel_wr = w_winner ? Wr1 : Wr0;

  always_comb begin
    w_state_nx  = r_state;
    w_cnt_nx    = r_cnt;
    w_grant_nx  = r_grant;
    w_wr_nx     = r_wr;
    w_addr_nx   = r_addr;
    w_wdata_nx  = r_wdata;
    w_rd_cmd_nx = r_rd_cmd;
    w_wr_cmd_nx = r_wr_cmd;
    w_done0_nx  = 1'b0;
    w_done1_nx  = 1'b0;
    w_rdata0_nx = r_rdata0;
    w_rdata1_nx = r_rdata1;
    w_busy_nx   = r_busy;
    case (r_state)
      IDLE: begin
        if (Req0 || Req1) begin
          w_grant_nx  = w_winner;
          w_wr_nx     = w_sel_wr;
          w_addr_nx   = w_winner ? Addr1 : Addr0;
          w_wdata_nx  = w_winner ? WData1 : WData0;
          w_rd_cmd_nx = ~w_sel_wr;
          w_wr_cmd_nx = w_sel_wr;
          w_cnt_nx    = c_CNT_LOAD;
          w_busy_nx   = 1'b1;
          w_state_nx  = ACCESS;
        end
      end
      ACCESS: begin
        if (r_cnt == '0) begin
          w_rd_cmd_nx = 1'b0;
          w_wr_cmd_nx = 1'b0;
          w_state_nx  = COMPLETE;
        end else begin
          w_cnt_nx = r_cnt - 1'b1;
        end
      end
      COMPLETE: begin
        // Memory address is still held, so ReadData has settled by now
        if (r_grant) begin
          w_done1_nx = 1'b1;
          if (!r_wr) w_rdata1_nx = MemReadData;
        end else begin
          w_done0_nx = 1'b1;
          if (!r_wr) w_rdata0_nx = MemReadData;
        end
        w_busy_nx  = 1'b0;
        w_state_nx = IDLE;
      end
      default: begin
        w_rd_cmd_nx = 1'b0;
        w_wr_cmd_nx = 1'b0;
        w_busy_nx   = 1'b0;
        w_state_nx  = IDLE;
      end
    endcase
  end

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      r_state  <= IDLE;
      r_cnt    <= '0;
      r_grant  <= 1'b0;
      r_wr     <= 1'b0;
      r_addr   <= '0;
      r_wdata  <= '0;
      r_rd_cmd <= 1'b0;
      r_wr_cmd <= 1'b0;
      r_done0  <= 1'b0;
      r_done1  <= 1'b0;
      r_rdata0 <= '0;
      r_rdata1 <= '0;
      r_busy   <= 1'b0;
    end else begin
      r_state  <= w_state_nx;
      r_cnt    <= w_cnt_nx;
      r_grant  <= w_grant_nx;
      r_wr     <= w_wr_nx;
      r_addr   <= w_addr_nx;
      r_wdata  <= w_wdata_nx;
      r_rd_cmd <= w_rd_cmd_nx;
      r_wr_cmd <= w_wr_cmd_nx;
      r_done0  <= w_done0_nx;
      r_done1  <= w_done1_nx;
      r_rdata0 <= w_rdata0_nx;
      r_rdata1 <= w_rdata1_nx;
      r_busy   <= w_busy_nx;
    end
  end

  assign Done0        = r_done0;
  assign Done1        = r_done1;
  assign RData0       = r_rdata0;
  assign RData1       = r_rdata1;
  assign MemAddress   = r_addr;
  assign MemWriteData = r_wdata;
  assign MemRead      = r_rd_cmd;
  assign MemWrite     = r_wr_cmd;
  assign Busy         = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_data_memory_arbiter.sv
`default_nettype none
// Directed bench for data_memory_arbiter with a posedge-read/negedge-write memory model.
module tb_data_memory_arbiter;

  logic        Clock = 1'b0;
  logic        Reset = 1'b0;
  logic        Req0 = 1'b0, Req1 = 1'b0, Wr0 = 1'b0, Wr1 = 1'b0;
  logic [63:0] Addr0 = '0, Addr1 = '0, WData0 = '0, WData1 = '0;
  logic        Done0, Done1, MemRead, MemWrite, Busy;
  logic [63:0] RData0, RData1, MemAddress, MemWriteData;
  logic [63:0] MemReadData = '0;

  logic [63:0] mem [0:15];
  bit          mutex_bad = 1'b0;
  int          checks = 0;
  int          errors = 0;

  data_memory_arbiter #(.ACCESS_CYCLES(2), .ADDR_W(64), .DATA_W(64)) dut (
    .Clock(Clock), .Reset(Reset),
    .Req0(Req0), .Req1(Req1), .Wr0(Wr0), .Wr1(Wr1),
    .Addr0(Addr0), .Addr1(Addr1), .WData0(WData0), .WData1(WData1),
    .Done0(Done0), .Done1(Done1), .RData0(RData0), .RData1(RData1),
    .MemAddress(MemAddress), .MemWriteData(MemWriteData),
    .MemRead(MemRead), .MemWrite(MemWrite), .MemReadData(MemReadData),
    .Busy(Busy)
  );

  always #50 Clock = ~Clock;

  always @(posedge Clock) if (MemRead) MemReadData <= #20 mem[MemAddress[3:0]];
  always @(negedge Clock) if (MemWrite) mem[MemAddress[3:0]] = MemWriteData;
  always @(negedge Clock) if (MemRead && MemWrite) mutex_bad = 1'b1;

  task automatic apply_reset();
    Reset = 1'b1; Req0 = 0; Req1 = 0;
    repeat (2) @(negedge Clock);
    Reset = 1'b0;
  endtask

  // Issues one request, holds it until Done or timeout; lat = negedges from request to Done
  task automatic do_access(input bit port, input bit wr, input logic [63:0] a,
                           input logic [63:0] d, output int lat,
                           output bit rd1, output bit wr1, output bit busy1);
    rd1 = 0; wr1 = 0; busy1 = 0; lat = -1;
    @(negedge Clock);
    if (port) begin Req1 = 1; Wr1 = wr; Addr1 = a; WData1 = d; end
    else      begin Req0 = 1; Wr0 = wr; Addr0 = a; WData0 = d; end
    for (int c = 1; c <= 20; c++) begin
      @(negedge Clock);
      if (c == 1) begin rd1 = MemRead; wr1 = MemWrite; busy1 = Busy; end
      if ((port ? Done1 : Done0) === 1'b1) begin lat = c; break; end
    end
    Req0 = 0; Req1 = 0;
  endtask

  task automatic test_reset();
    Reset = 1'b1;
    repeat (2) @(negedge Clock);
    checks++; if ({Done0, Done1, MemRead, MemWrite, Busy} !== 5'b0) begin
      errors++; $display("FAIL reset_ctrl got=%b exp=00000", {Done0, Done1, MemRead, MemWrite, Busy});
    end
    checks++; if ({RData0, RData1, MemAddress, MemWriteData} !== 256'd0) begin
      errors++; $display("FAIL reset_data got=%h/%h/%h/%h exp=0", RData0, RData1, MemAddress, MemWriteData);
    end
    Reset = 1'b0;
  endtask

  task automatic test_write_read();
    int lat; bit r1, w1, b1;
    do_access(0, 1, 64'd5, 64'hDEAD, lat, r1, w1, b1);
    checks++; if (lat !== 4) begin errors++; $display("FAIL wr_latency got=%0d exp=4", lat); end
    checks++; if ({r1, w1, b1} !== 3'b011) begin errors++; $display("FAIL wr_cmd got=%b exp=011", {r1, w1, b1}); end
    checks++; if (mem[5] !== 64'hDEAD) begin errors++; $display("FAIL wr_commit got=%h exp=dead", mem[5]); end
    do_access(0, 0, 64'd5, 64'd0, lat, r1, w1, b1);
    checks++; if (lat !== 4) begin errors++; $display("FAIL rd_latency got=%0d exp=4", lat); end
    checks++; if ({r1, w1, b1} !== 3'b101) begin errors++; $display("FAIL rd_cmd got=%b exp=101", {r1, w1, b1}); end
    checks++; if (RData0 !== 64'hDEAD) begin errors++; $display("FAIL rd_data got=%h exp=dead", RData0); end
    checks++; if (Busy !== 1'b0) begin errors++; $display("FAIL busy_at_done got=%b exp=0", Busy); end
  endtask

  task automatic test_simultaneous();
    int c0, c1;
    apply_reset();
    c0 = -1; c1 = -1;
    @(negedge Clock);
    Req0 = 1; Wr0 = 1; Addr0 = 64'd1; WData0 = 64'd7;
    Req1 = 1; Wr1 = 0; Addr1 = 64'd1;
    for (int c = 1; c <= 30 && c1 < 0; c++) begin
      @(negedge Clock);
      if (Done0 === 1'b1 && c0 < 0) begin c0 = c; Req0 = 0; end
      if (Done1 === 1'b1) begin c1 = c; Req1 = 0; end
    end
    Req0 = 0; Req1 = 0;
    checks++; if (c0 !== 4) begin errors++; $display("FAIL tie_port0_first got=%0d exp=4", c0); end
    checks++; if (c1 !== 8) begin errors++; $display("FAIL tie_port1_next got=%0d exp=8", c1); end
    checks++; if (RData1 !== 64'd7) begin errors++; $display("FAIL tie_rdata1 got=%h exp=7", RData1); end
  endtask

  task automatic test_round_robin();
    int seq [4];
    int n;
    bit both;
    n = 0; both = 0;
    @(negedge Clock);
    Req0 = 1; Req1 = 1; Wr0 = 0; Wr1 = 0; Addr0 = 64'd5; Addr1 = 64'd1;
    for (int c = 0; c < 40 && n < 4; c++) begin
      @(negedge Clock);
      if (Done0 && Done1) both = 1;
      if (Done0 === 1'b1) begin seq[n] = 0; n++; end
      else if (Done1 === 1'b1) begin seq[n] = 1; n++; end
    end
    Req0 = 0; Req1 = 0;
    checks++; if (n !== 4) begin errors++; $display("FAIL rr_count got=%0d exp=4", n); end
    checks++; if ({seq[0][0], seq[1][0], seq[2][0], seq[3][0]} !== 4'b0101) begin
      errors++; $display("FAIL rr_order got=%0d%0d%0d%0d exp=0101", seq[0], seq[1], seq[2], seq[3]);
    end
    checks++; if (both !== 1'b0) begin errors++; $display("FAIL rr_dual_done got=%b exp=0", both); end
  endtask

  task automatic test_reset_mid();
    int lat; bit r1, w1, b1;
    @(negedge Clock);
    Req0 = 1; Wr0 = 1; Addr0 = 64'd9; WData0 = 64'h55;
    @(negedge Clock);
    checks++; if ({MemWrite, Busy} !== 2'b11) begin errors++; $display("FAIL mid_active got=%b exp=11", {MemWrite, Busy}); end
    #10 Reset = 1'b1;
    #1;
    checks++; if ({MemRead, MemWrite, Done0, Done1, Busy} !== 5'b0) begin
      errors++; $display("FAIL mid_async_clear got=%b exp=00000", {MemRead, MemWrite, Done0, Done1, Busy});
    end
    Req0 = 0;
    @(negedge Clock);
    Reset = 1'b0;
    do_access(0, 0, 64'd1, 64'd0, lat, r1, w1, b1);
    checks++; if (lat !== 4) begin errors++; $display("FAIL post_reset_lat got=%0d exp=4", lat); end
    checks++; if (RData0 !== 64'd7) begin errors++; $display("FAIL post_reset_rdata got=%h exp=7", RData0); end
  endtask

  task automatic test_req_drop();
    int d0, d1;
    d0 = 0; d1 = 0;
    @(negedge Clock);
    Req1 = 1; Wr1 = 0; Addr1 = 64'd3;
    @(negedge Clock);
    Req1 = 0;
    for (int c = 0; c < 10; c++) begin
      @(negedge Clock);
      if (Done0 === 1'b1) d0++;
      if (Done1 === 1'b1) d1++;
    end
    checks++; if (d1 !== 1) begin errors++; $display("FAIL drop_done1 got=%0d exp=1", d1); end
    checks++; if (d0 !== 0) begin errors++; $display("FAIL drop_done0 got=%0d exp=0", d0); end
    checks++; if (RData1 !== 64'h1003) begin errors++; $display("FAIL drop_rdata got=%h exp=1003", RData1); end
    checks++; if (Busy !== 1'b0) begin errors++; $display("FAIL drop_busy got=%b exp=0", Busy); end
  endtask

`ifdef DMEM_ARB_FIXED_PRIO_EN
  task automatic test_fixed_prio();
    int d0, d1;
    bit seen;
    d0 = 0; d1 = 0; seen = 0;
    @(negedge Clock);
    Req0 = 1; Req1 = 1; Wr0 = 0; Wr1 = 0; Addr0 = 64'd5; Addr1 = 64'd3;
    for (int c = 0; c < 20; c++) begin
      @(negedge Clock);
      if (Done0 === 1'b1) d0++;
      if (Done1 === 1'b1) d1++;
    end
    Req0 = 0;
    for (int c = 0; c < 20 && !seen; c++) begin
      @(negedge Clock);
      if (Done1 === 1'b1) seen = 1;
    end
    Req1 = 0;
    checks++; if (d1 !== 0) begin errors++; $display("FAIL fixed_no_done1 got=%0d exp=0", d1); end
    checks++; if (d0 < 4) begin errors++; $display("FAIL fixed_done0 got=%0d exp>=4", d0); end
    checks++; if (seen !== 1'b1) begin errors++; $display("FAIL fixed_release got=%b exp=1", seen); end
  endtask
`endif

  task automatic test_mutex();
    checks++; if (mutex_bad !== 1'b0) begin errors++; $display("FAIL mem_mutex got=%b exp=0", mutex_bad); end
  endtask

  initial begin
    for (int i = 0; i < 16; i++) mem[i] = 64'h1000 + 64'(i);
    test_reset();
    test_write_read();
    test_simultaneous();
    test_round_robin();
    test_reset_mid();
    test_req_drop();
`ifdef DMEM_ARB_FIXED_PRIO_EN
    test_fixed_prio();
`endif
    test_mutex();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
